sd_pic_loader: RTL

Streams a raw 12-bit-per-pixel image from consecutive SD card sectors into the picture frame buffer. Sits between the SPI SD controller (byte stream: `ready`/`rd`/`address`/`byte_available`/`dout`) and the frame buffer RAM write port. It sequences sector reads and packs every 3 bytes into two 12-bit pixels that cross sector boundaries. It raises `done` once the whole frame is written.

---
 rtl/sd_pic_pkg.sv | 19 +
 rtl/sd_pic_loader_packer.sv | 59 +++++
 rtl/sd_pic_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sd_pic_pkg.sv
// Shared types and constants for the SD-card picture loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_READY,
    ST_READ,
    ST_WRITE_HI,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int          SECTOR_BYTES     = 512;
  localparam int          BYTES_PER_PAIR   = 3;
  localparam logic [31:0] DEF_START_SECTOR = 32'h0000_43C0;

endpackage

// File: rtl/sd_pic_loader_packer.sv
// Packs a byte stream into pixel pairs: bytes b0,b1,b2 form {b2,b1,b0}, low 12 bits first.
// Latency: low pixel combinational with the third byte, high pixel registered one cycle later.
// Backpressure: none; accepts one byte per byte_vld, state persists until clear.
// Ports: clk/rst_n; clear restarts the triplet; byte_vld/byte_dat byte in;
//        pair_valid marks the third byte; pix_lo is valid with it, pix_hi from the next cycle.
module pixel_packer
  import sd_pic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        pair_valid,
  output logic [11:0] pix_lo,
  output logic [11:0] pix_hi
);

  localparam logic [1:0] TRIP_LAST = 2'(BYTES_PER_PAIR - 1);

  logic [1:0]  trip_q, trip_d;
  // Only the two pending bytes {b1,b0} are held; the third byte is used straight
  // off the input, so the full 24-bit word never needs to exist as a register.
  logic [15:0] sr_q, sr_d;
  logic [11:0] hi_q, hi_d;

  assign pair_valid = byte_vld && (trip_q == TRIP_LAST);
  assign pix_lo     = sr_q[11:0];
  assign pix_hi     = hi_q;

  always_comb begin
    trip_d = trip_q;
    sr_d   = sr_q;
    hi_d   = hi_q;
    if (clear) begin
      trip_d = 2'd0;
      sr_d   = 16'd0;
    end else if (byte_vld) begin
      sr_d   = {byte_dat, sr_q[15:8]};
      trip_d = pair_valid ? 2'd0 : trip_q + 2'd1;
      if (pair_valid) begin
        hi_d = {byte_dat, sr_q[15:12]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trip_q <= 2'd0;
      sr_q   <= 16'd0;
      hi_q   <= 12'd0;
    end else begin
      trip_q <= trip_d;
      sr_q   <= sr_d;
      hi_q   <= hi_d;
    end
  end

endmodule

// File: rtl/sd_pic_loader.sv
// Streams a 12-bit/pixel raw image from consecutive SD sectors into the frame buffer.
// Latency: pixel writes 1 and 2 cycles after the third byte of each triplet; done 1 cycle after last byte.
// Backpressure: none toward the SD controller; sector reads issued only when sd_ready, timeout guards stalls.
// Ports: CLK/RST; start/busy/done/error control; sd_* byte-stream read port of the SPI SD
//        controller; fb_we/fb_addr/fb_din frame buffer write port. All outputs registered.
module sd_pic_loader
  import sd_pic_pkg::*;
#(
  parameter logic [31:0] START_SECTOR = DEF_START_SECTOR,
  parameter int          PIXEL_COUNT  = 120000,
  parameter int          FB_AW        = 17,
  parameter logic [23:0] TIMEOUT      = 24'd10_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  input  logic             sd_ready,
  output logic             sd_rd,
  output logic [31:0]      sd_address,
  input  logic             sd_byte_available,
  input  logic [7:0]       sd_dout,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [11:0]      fb_din
);

  localparam logic [8:0]       LAST_BYTE = 9'(SECTOR_BYTES - 1);
  // Pixel counter is one bit wider than the address so PIXEL_COUNT = 2^FB_AW is reachable.
  localparam logic [FB_AW:0]   PIX_TOTAL = (FB_AW + 1)'(PIXEL_COUNT);
  localparam logic [FB_AW:0]   PIX_STEP  = (FB_AW + 1)'(2);
  localparam logic [FB_AW-1:0] ADDR_ONE  = FB_AW'(1);

  state_t            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic              sd_rd_q, sd_rd_d;
  logic [31:0]       sd_address_q, sd_address_d;
  logic              fb_we_q, fb_we_d;
  logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;
  logic [11:0]       fb_din_q, fb_din_d;
  logic [8:0]        byte_cnt_q, byte_cnt_d;
  logic [FB_AW:0]    pix_q, pix_d;
  logic [23:0]       tmo_q, tmo_d;
  logic              sector_end_q, sector_end_d;

  logic              pk_clear, pk_vld, pair_valid;
  logic [11:0]       pix_lo, pix_hi;
  logic              last_byte, frame_full;
  logic [FB_AW:0]    pix_next;

  assign pk_vld     = (state_q == ST_READ) && sd_byte_available;
  assign last_byte  = (byte_cnt_q == LAST_BYTE);
  assign frame_full = (pix_q == PIX_TOTAL);
  assign pix_next   = pix_q + PIX_STEP;

  pixel_packer u_packer (
    .clk        (CLK),
    .rst_n      (RST),
    .clear      (pk_clear),
    .byte_vld   (pk_vld),
    .byte_dat   (sd_dout),
    .pair_valid (pair_valid),
    .pix_lo     (pix_lo),
    .pix_hi     (pix_hi)
  );

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    sd_rd_d      = sd_rd_q;
    sd_address_d = sd_address_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_din_d     = fb_din_q;
    byte_cnt_d   = byte_cnt_q;
    pix_d        = pix_q;
    tmo_d        = tmo_q;
    sector_end_d = sector_end_q;
    pk_clear     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d      = ST_WAIT_READY;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          sd_address_d = START_SECTOR;
          byte_cnt_d   = 9'd0;
          pix_d        = '0;
          tmo_d        = 24'd0;
          sector_end_d = 1'b0;
          pk_clear     = 1'b1;
        end
      end
      ST_WAIT_READY: begin
        if (sd_ready) begin
          sd_rd_d = 1'b1;
          tmo_d   = 24'd0;
          state_d = ST_READ;
        end else if (tmo_q == TIMEOUT) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      ST_READ: begin
        if (sd_byte_available) begin
          tmo_d      = 24'd0;
          byte_cnt_d = byte_cnt_q + 9'd1;
          if (last_byte) begin
            sd_rd_d      = 1'b0;
            sd_address_d = sd_address_q + 32'd1;
          end
          if (frame_full) begin
            // Frame already written: drain the rest of the sector so the
            // controller always completes whole-sector reads.
            if (last_byte) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else if (pair_valid) begin
            fb_we_d      = 1'b1;
            fb_addr_d    = pix_q[FB_AW-1:0];
            fb_din_d     = pix_lo;
            sector_end_d = last_byte;
            state_d      = ST_WRITE_HI;
          end else if (last_byte) begin
            state_d = ST_WAIT_READY;
          end
        end else if (tmo_q == TIMEOUT) begin
          sd_rd_d = 1'b0;
          state_d = ST_ERROR;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      ST_WRITE_HI: begin
        fb_we_d   = 1'b1;
        fb_addr_d = pix_q[FB_AW-1:0] + ADDR_ONE;
        fb_din_d  = pix_hi;
        pix_d     = pix_next;
        tmo_d     = 24'd0;
        if (!sector_end_q) begin
          state_d = ST_READ;
        end else if (pix_next == PIX_TOTAL) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_WAIT_READY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      sd_rd_q      <= 1'b0;
      sd_address_q <= START_SECTOR;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_din_q     <= 12'd0;
      byte_cnt_q   <= 9'd0;
      pix_q        <= '0;
      tmo_q        <= 24'd0;
      sector_end_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      sd_rd_q      <= sd_rd_d;
      sd_address_q <= sd_address_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_din_q     <= fb_din_d;
      byte_cnt_q   <= byte_cnt_d;
      pix_q        <= pix_d;
      tmo_q        <= tmo_d;
      sector_end_q <= sector_end_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign sd_rd      = sd_rd_q;
  assign sd_address = sd_address_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_din     = fb_din_q;

endmodule
